// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits, none/odd/even parity,
// 1..2 stop bits) with parity, framing and overrun reporting on a valid/ready output.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   rx            serial line, idle high, asynchronous to clk
//   rx_data       received character, LSB first on the line
//   rx_valid      rx_data and flags valid, held until rx_ready
//   rx_ready      consumer accepts when rx_valid && rx_ready
//   rx_parity_err parity mismatch for the held character
//   rx_frame_err  a stop bit was sampled low for the held character
//   rx_overrun    one-cycle pulse when a completed frame is dropped
//   busy          receiver is inside a frame
module uart_rx_param #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 busy
);
    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS + 1);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_rx_param: CLK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DELIVER} state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n, data_n;
    logic                 pe_p, pe_pn, fe_p, fe_pn;
    logic                 valid_n, pe_n, fe_n, ov_n;
    logic                 tick;

    assign tick = cnt == CW'(CPB - 1);
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            sh            <= '0;
            pe_p          <= 1'b0;
            fe_p          <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_m          <= rx;
            rx_s          <= rx_m;
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            sh            <= sh_n;
            pe_p          <= pe_pn;
            fe_p          <= fe_pn;
            rx_data       <= data_n;
            rx_valid      <= valid_n;
            rx_parity_err <= pe_n;
            rx_frame_err  <= fe_n;
            rx_overrun    <= ov_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        pe_pn   = pe_p;
        fe_pn   = fe_p;
        data_n  = rx_data;
        valid_n = rx_valid && !rx_ready;
        pe_n    = rx_parity_err;
        fe_n    = rx_frame_err;
        ov_n    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                // Re-check the line at half a bit to reject short glitches.
                if (cnt == CW'(HALF - 1)) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    pe_pn   = 1'b0;
                    fe_pn   = 1'b0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_n = '0;
                    // Shift in at the top so the first (LSB) bit ends up in bit 0.
                    sh_n  = {rx_s, sh[DATA_BITS-1:1]};
                    idx_n = idx + 1'b1;
                    if (idx == BW'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = PARITY != 0 ? PAR : STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PAR: begin
                if (tick) begin
                    cnt_n   = '0;
                    pe_pn   = rx_s != (PARITY == 2 ? ^sh : ~^sh);
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_n = '0;
                    fe_pn = fe_p || !rx_s;
                    idx_n = idx + 1'b1;
                    if (idx == BW'(STOP_BITS - 1)) state_n = DELIVER;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DELIVER: begin
                // A still-pending character wins; the new frame is dropped.
                if (!rx_valid || rx_ready) begin
                    data_n  = sh;
                    valid_n = 1'b1;
                    pe_n    = pe_p;
                    fe_n    = fe_p;
                end else begin
                    ov_n = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver replacing the fixed 8N1 receiver at the front of the UART-to-DDR data path. Supports configurable data bits, parity mode, stop-bit count and baud divisor. It reports parity, framing and overrun errors. Delivers each received character on a valid/ready interface to the downstream async FIFO write side.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in baud
- DATA_BITS, 8, character width; legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits checked; legal 1..2

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rx  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  DATA_BITS  received character, LSB first on the line
- rx_valid  out  1  rx_data/flags valid; held until accepted
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready
- rx_parity_err  out  1  parity mismatch for the held character
- rx_frame_err  out  1  any stop bit sampled low for the held character
- rx_overrun  out  1  one-cycle pulse: a frame completed while rx_valid was still pending
- busy  out  1  high in any state other than IDLE

## Operation
- Internal constants:
  - CPB = CLK_FREQ / BAUD_RATE, integer division; elaboration error if CPB < 4.
  - HALF = CPB / 2.
  - The counter is $clog2(CPB) bits wide.
- rx passes through a 2-flop synchroniser, giving rx_s; the FSM uses rx_s only. The synchroniser resets to 1.
- FSM states and transitions:
  - IDLE: when rx_s == 0, clear the counter and go to START.
  - START: increment the counter. At count HALF-1, sample rx_s.
    - If 0, this is a valid start bit: clear the counter and bit index, go to DATA.
    - If 1, it was a glitch: go to IDLE with no output.
  - DATA: at count CPB-1, sample rx_s into a shift register (LSB first) and clear the counter. After DATA_BITS samples, go to PAR if PARITY != 0, else STOP.
  - PAR: at count CPB-1, sample the parity bit.
    - Expected parity for even mode is ^data; for odd mode it is ~^data.
    - A mismatch sets the pending parity error.
  - STOP: at count CPB-1, sample each stop bit; any 0 sets the pending framing error. After STOP_BITS samples, go to DELIVER.
  - DELIVER: single cycle.
    - If rx_valid == 0 or rx_ready == 1 in this cycle, load rx_data and both error flags, and set rx_valid.
    - Otherwise, drop the new frame, keep the held character, and pulse rx_overrun.
    - Go to IDLE.
- Sampling therefore falls at mid-bit (HALF + k*CPB after the detected falling edge). Return to IDLE is mid-way through the last stop bit, so back-to-back frames with no idle time are received.
- Characters with parity or framing errors are still delivered, with their flag set. Flags are updated only when rx_data loads.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready, unless DELIVER loads a new character that same cycle, in which case it stays 1.
  - rx_data and the flags are stable while rx_valid && !rx_ready.

## Timing
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; counter and shift register are 0.
  - rx_data = 0, rx_valid = 0, rx_parity_err = 0, rx_frame_err = 0, rx_overrun = 0, busy = 0.
- Reset mid-frame discards the partial frame. After release, the receiver waits for rx_s high-to-low in IDLE. If the line is already low, it treats this as a start edge, and START validation applies.
- Latency:
  - A falling rx edge is seen in rx_s 2 clk later.
  - rx_valid rises HALF + (DATA_BITS + P + STOP_BITS - 1)*CPB + CPB + 2 cycles after the IDLE→START transition, where P = (PARITY != 0).
  - This value is exact and is checked by the bench.
- Throughput: one character per frame time; no backpressure to the line. rx_overrun is the only loss indication.
- rx_overrun is high for exactly 1 cycle per dropped frame.

## Test plan
- 8N1, CPB = 868: send 0xA5 with rx_ready = 1 → rx_valid for 1 cycle, rx_data = 0xA5, both error flags 0, latency equals the Timing formula.
- 8E1: send 0x07 with parity bit 1 → parity_err = 0. Send 0x07 with parity bit 0 → rx_data = 0x07, parity_err = 1. Repeat in 7O2 with 0x55 and parity bit 1 → no error.
- Stop bit driven low for 8N1 0x3C → rx_data = 0x3C, frame_err = 1. With STOP_BITS = 2, drive only the second stop bit low → frame_err = 1.
- Glitch: rx low for 200 cycles (< HALF) then high → no rx_valid, busy returns to 0, next frame 0x81 received correctly.
- Overrun: rx_ready = 0, send 0x11 then 0x22 back-to-back → rx_data stays 0x11, rx_overrun pulses once at the 0x22 DELIVER. Then rx_ready = 1 → rx_valid drops and the next frame 0x33 is delivered.
- Reset mid-frame: assert rst during the DATA bit 3 of 0xF0 → all outputs 0 immediately. After release, a full 0x5A frame is received correctly.
